sat_tx_frame_modulator: RTL and testbench
=========================================

Name: sat_tx_frame_modulator

Overview:
Parametrised transmit-path successor to the fixed QPSK modulator/encoder pair in the satellite DSP system. Accepts an information bit stream and emits framed baseband I/Q symbols. Each frame is an uncoded sync preamble, then a rate-1/2 K=7 convolutionally encoded payload with trellis-terminating tail. Modulation mode (BPSK/QPSK) is selectable per frame. Sits between the bit source and the DAC/pulse-shaping stage, with valid/ready on both sides.

Parameters:
IQ_W, 16, signed width of out_i/out_q
AMP, 16'sd11585, symbol amplitude magnitude (0.707 in Q1.14); bit 0 -> +AMP, bit 1 -> -AMP
PREAMBLE_LEN, 32, preamble length in bits (1..32)
PREAMBLE, 32'h1ACFFC1D, sync word; the top PREAMBLE_LEN bits are sent MSB first
PAYLOAD_LEN, 256, information bits per frame (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  1  0=BPSK, 1=QPSK; sampled only on the IDLE->PREAMBLE transition
in_valid  in  1  info bit valid
in_bit  in  1  info bit
in_ready  out  1  block accepts in_bit this cycle
out_valid  out  1  symbol valid
out_ready  in  1  downstream accepts the symbol
out_i  out  IQ_W  in-phase sample, signed
out_q  out  IQ_W  quadrature sample, signed
out_sof  out  1  high with the first preamble symbol
out_eof  out  1  high with the last tail symbol
underrun  out  1  one-cycle pulse on any PAYLOAD cycle where a bit is needed, in_valid=0, and the output register is empty or being consumed
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM=IDLE; encoder state 0; all counters 0; registered mode 0. Outputs: out_valid=0, out_i=out_q=0, out_sof=out_eof=0, in_ready=0, underrun=0, busy=0. Reset mid-frame aborts the frame immediately, with no EOF.
- Output register: loads a new symbol only when (!out_valid || out_ready); otherwise it holds all outputs stable. A symbol appears one cycle after the internal event that produced it.
- FSM IDLE: when in_valid=1, latch mode, clear the encoder shift register, and go to PREAMBLE. The bit is not consumed.
- FSM PREAMBLE: emits PREAMBLE_LEN symbols as BPSK (I=±AMP, Q=0), one bit per load, regardless of mode. The first carries out_sof. in_ready=0. After the last load, go to PAYLOAD.
- FSM PAYLOAD: encoder G1=171o, G2=133o; newest bit at the MSB tap; produces c0 (G1) and c1 (G2).
  - QPSK: one bit accepted per load; I=map(c0), Q=map(c1).
  - BPSK: a bit is accepted on phase 0 and emits map(c0) on I. Phase 1 emits the stored map(c1) with in_ready=0. Q=0.
  - in_ready = PAYLOAD && needs-bit phase && (!out_valid || out_ready).
  - If in_valid=0 when a bit is needed: no load (out_valid drops after the current symbol drains), underrun pulses, and the frame resumes when data returns.
  - After PAYLOAD_LEN bits are accepted, go to FLUSH.
- FSM FLUSH: 6 internal zero bits, encoded and mapped as in PAYLOAD; in_ready=0. The final symbol carries out_eof. Then IDLE.
- Symbols per frame: PREAMBLE_LEN + 2*(PAYLOAD_LEN+6) for BPSK; PREAMBLE_LEN + PAYLOAD_LEN + 6 for QPSK.
- Back-to-back frames: IDLE lasts one cycle minimum. mode changes take effect only at the next frame start.
- Simultaneous load and out_ready: the new symbol replaces the old one in the same edge (no bubble under continuous flow).
- Arithmetic: mapping is ±AMP sign-extended/truncated to IQ_W. No scaling elsewhere.

Optional Feature:
Macro SCRAMBLER_EN.
- Defined: info bits (payload only; preamble and tail excluded) are XORed with a Fibonacci LFSR x^8+x^7+x^5+x^3+1 before encoding. The LFSR is seeded 8'hFF at each frame start and advances once per accepted info bit; the output bit is the LFSR MSB.
- Undefined: info bits go directly to the encoder and no LFSR logic exists.

Test Plan:
1. Preamble: PAYLOAD_LEN=8, mode=0, out_ready=1, in_valid=1 -> the first 4 symbols are I=+11585,+11585,+11585,-11585 (bits 0001), Q=0; out_sof only on symbol 1; symbol count=32.
2. BPSK encode: payload bit 1 first after preamble (SCRAMBLER_EN undefined) -> next two symbols I=-11585,-11585, Q=0; frame totals 32+28=60 symbols; out_eof on symbol 60; busy falls the next cycle.
3. QPSK: mode=1, payload all zeros -> 8+6 payload/tail symbols, all I=Q=+11585; total 46 symbols; mode toggled mid-frame has no effect.
4. Backpressure: hold out_ready=0 for 5 cycles mid-payload -> out_i/out_q/out_valid stable, in_ready=0, no bits lost; the full symbol sequence matches the golden model.
5. Underrun: drop in_valid for 3 cycles mid-payload with out_ready=1 -> underrun pulses, out_valid gaps, and the frame completes with the correct symbol count and values.
6. Reset mid-frame at symbol 40 -> the next cycle has all outputs 0 and FSM IDLE; a new frame restarts cleanly with out_sof and the preamble.

Source files
------------

// File: rtl/sat_tx_frame_modulator.sv
// Framed BPSK/QPSK transmitter: uncoded sync preamble, then a K=7 rate-1/2 coded payload with a 6-bit zero tail.
// Optional payload scrambler (x^8+x^7+x^5+x^3+1, seeded 8'hFF each frame) is built when SCRAMBLER_EN is defined.
module sat_tx_frame_modulator #(
  parameter int                 IQ_W         = 16,
  parameter logic signed [15:0] AMP          = 16'sd11585,
  parameter int                 PREAMBLE_LEN = 32,
  parameter logic [31:0]        PREAMBLE     = 32'h1ACFFC1D,
  parameter int                 PAYLOAD_LEN  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IQ_W-1:0] out_i,
  output logic signed [IQ_W-1:0] out_q,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   underrun,
  output logic                   busy
);
  localparam int CMAX = (PAYLOAD_LEN > PREAMBLE_LEN) ? PAYLOAD_LEN : PREAMBLE_LEN;
  localparam int CW   = $clog2(CMAX + 8);
  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] G2 = 7'o133;
  localparam logic signed [IQ_W-1:0] POS = IQ_W'(AMP);
  localparam logic signed [IQ_W-1:0] NEG = -POS;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d, ph_q, ph_d, c1_q, c1_d;
  logic [5:0]             enc_q, enc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   vld_q, vld_d, sof_q, sof_d, eof_q, eof_d, und_q, und_d;
  logic signed [IQ_W-1:0] i_q, i_d, oq_q, oq_d;

  logic       ld, need_bit, src, c0, c1, last, take, start, scr;
  logic [6:0] win;
  logic [31:0] pre_w;

  function automatic logic signed [IQ_W-1:0] map(input logic b);
    return b ? NEG : POS;
  endfunction

  assign start = (state_q == S_IDLE) && in_valid;

`ifdef SCRAMBLER_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign scr = lfsr_q[7];
  always_comb begin
    lfsr_d = lfsr_q;
    if (start) lfsr_d = 8'hFF;
    else if (take && state_q == S_PAY)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[6] ^ lfsr_q[4] ^ lfsr_q[2]};
  end
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= '0;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign scr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;  mode_d = mode_q;  enc_d = enc_q;  cnt_d = cnt_q;
    ph_d    = ph_q;     c1_d   = c1_q;
    ld      = !vld_q || out_ready;
    // A consumed symbol with no replacement drains the output register.
    vld_d   = vld_q && !ld;
    sof_d   = sof_q && !ld;
    eof_d   = eof_q && !ld;
    i_d     = i_q;
    oq_d    = oq_q;
    und_d   = 1'b0;
    take    = 1'b0;
    need_bit = mode_q || !ph_q;
    src     = (state_q == S_FLUSH) ? 1'b0 : (in_bit ^ scr);
    win     = {src, enc_q};
    c0      = ^(win & G1);
    c1      = ^(win & G2);
    last    = (state_q == S_FLUSH) ? (cnt_q == CW'(5)) : (cnt_q == CW'(PAYLOAD_LEN - 1));
    pre_w   = PREAMBLE << cnt_q;

    case (state_q)
      S_IDLE: if (in_valid) begin
        mode_d  = mode;
        enc_d   = '0;
        cnt_d   = '0;
        ph_d    = 1'b0;
        state_d = S_PRE;
      end
      S_PRE: if (ld) begin
        vld_d = 1'b1;
        i_d   = map(pre_w[31]);
        oq_d  = '0;
        sof_d = (cnt_q == '0);
        if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_PAY;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_PAY, S_FLUSH: if (ld) begin
        if (!need_bit) begin
          vld_d = 1'b1;
          i_d   = map(c1_q);
          oq_d  = '0;
          ph_d  = 1'b0;
          take  = 1'b0;
        end else if (state_q == S_FLUSH || in_valid) begin
          take  = 1'b1;
          enc_d = win[6:1];
          vld_d = 1'b1;
          i_d   = map(c0);
          oq_d  = mode_q ? map(c1) : '0;
          c1_d  = c1;
          ph_d  = !mode_q;
        end else begin
          und_d = (state_q == S_PAY);
        end
        // A bit slot closes after its last symbol: QPSK on accept, BPSK on phase 1.
        if ((!need_bit) || (take && mode_q)) begin
          if (last) begin
            cnt_d = '0;
            if (state_q == S_PAY) state_d = S_FLUSH;
            else begin
              state_d = S_IDLE;
              eof_d   = 1'b1;
            end
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  mode_q <= 1'b0;  enc_q <= '0;  cnt_q <= '0;
      ph_q    <= 1'b0;    c1_q   <= 1'b0;  vld_q <= 1'b0;
      i_q     <= '0;      oq_q   <= '0;    sof_q <= 1'b0; eof_q <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; enc_q <= enc_d; cnt_q <= cnt_d;
      ph_q    <= ph_d;    c1_q   <= c1_d;   vld_q <= vld_d;
      i_q     <= i_d;     oq_q   <= oq_d;   sof_q <= sof_d; eof_q <= eof_d;
      und_q   <= und_d;
    end
  end

  assign in_ready  = (state_q == S_PAY) && need_bit && ld;
  assign out_valid = vld_q;
  assign out_i     = i_q;
  assign out_q     = oq_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign underrun  = und_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sat_tx_frame_modulator.sv
// Bench for sat_tx_frame_modulator: frame scenarios from a table, scored against a symbol-list model.
module tb_sat_tx_frame_modulator;
  localparam int PL = 8;
  localparam int PLEN = 32;
  localparam int A = 11585;

  logic clk = 1'b0, reset = 1'b1, mode = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_sof, out_eof, underrun, busy;
  logic signed [15:0] out_i, out_q;

  sat_tx_frame_modulator #(.IQ_W(16), .AMP(16'sd11585), .PREAMBLE_LEN(PLEN),
    .PREAMBLE(32'h1ACFFC1D), .PAYLOAD_LEN(PL)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
    .out_q(out_q), .out_sof(out_sof), .out_eof(out_eof), .underrun(underrun), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int i; int q; bit sof; bit eof; } sym_t;
  typedef struct { bit m; int pat; int stall_at; int gap_at; bit tog; int exp_n; } vec_t;

  sym_t exp_q[$];
  sym_t got_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: list every symbol of a frame straight from the framing and code rules.
  function automatic void build_model(input bit m, input bit [PL-1:0] pay);
    logic [31:0] pw = 32'h1ACFFC1D;
    int u[PL+6];
    int c0, c1;
    logic [7:0] lf = 8'hFF;
    exp_q.delete();
    for (int k = 0; k < PLEN; k++)
      exp_q.push_back('{pw[31-k] ? -A : A, 0, k == 0, 1'b0});
    for (int n = 0; n < PL + 6; n++) begin
      u[n] = (n < PL) ? int'(pay[n]) : 0;
`ifdef SCRAMBLER_EN
      if (n < PL) begin
        u[n] = u[n] ^ int'(lf[7]);
        lf = {lf[6:0], lf[7] ^ lf[6] ^ lf[4] ^ lf[2]};
      end
`endif
    end
    for (int n = 0; n < PL + 6; n++) begin
      // 171o taps delays 0,1,2,3,6; 133o taps delays 0,2,3,5,6
      c0 = u[n] ^ (n>=1 ? u[n-1] : 0) ^ (n>=2 ? u[n-2] : 0) ^ (n>=3 ? u[n-3] : 0) ^ (n>=6 ? u[n-6] : 0);
      c1 = u[n] ^ (n>=2 ? u[n-2] : 0) ^ (n>=3 ? u[n-3] : 0) ^ (n>=5 ? u[n-5] : 0) ^ (n>=6 ? u[n-6] : 0);
      if (m) exp_q.push_back('{c0 ? -A : A, c1 ? -A : A, 1'b0, 1'b0});
      else begin
        exp_q.push_back('{c0 ? -A : A, 0, 1'b0, 1'b0});
        exp_q.push_back('{c1 ? -A : A, 0, 1'b0, 1'b0});
      end
    end
    exp_q[exp_q.size()-1].eof = 1'b1;
  endfunction

  task automatic run_frame(input bit m, input bit [PL-1:0] pay, input int stall_at,
                           input int gap_at, input bit tog, input int abort_at, input int exp_n);
    int bi = 0, gap_left = 0, stall_left = 0, cyc = 0, und = 0;
    bit done = 0, stall_used = 0, gap_used = 0;
    sym_t held;
    build_model(m, pay);
    got_q.delete();
    mode = m;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (tog && busy) mode = ~mode;
      if (stall_at > 0 && !stall_used && got_q.size() == stall_at) begin
        stall_left = 5; stall_used = 1;
      end
      out_ready = (stall_left == 0);
      if (gap_at > 0 && !gap_used && bi == gap_at) begin
        gap_left = 3; gap_used = 1;
      end
      in_valid = (bi < PL) && (gap_left == 0);
      in_bit   = (bi < PL) ? pay[bi] : 1'b0;
      #1;
      if (underrun) und++;
      if (stall_left > 0) begin
        if (stall_left < 5) begin
          chk("stall_valid", int'(out_valid), int'(held.sof));
          chk("stall_i", int'(out_i), held.i);
          chk("stall_q", int'(out_q), held.q);
        end
        chk("stall_in_ready", int'(in_ready), 0);
        held = '{int'(out_i), int'(out_q), out_valid, 1'b0};
        stall_left--;
      end
      if (gap_left > 0) gap_left--;
      if (in_valid && in_ready) bi++;
      if (out_valid && out_ready) begin
        got_q.push_back('{int'(out_i), int'(out_q), out_sof, out_eof});
        if (out_eof) done = 1;
        if (abort_at > 0 && got_q.size() == abort_at) return;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("frame_done", int'(done), 1);
    chk("sym_count", got_q.size(), exp_n);
    chk("model_count", exp_q.size(), exp_n);
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      chk($sformatf("sym%0d_i", k), got_q[k].i, exp_q[k].i);
      chk($sformatf("sym%0d_q", k), got_q[k].q, exp_q[k].q);
      chk($sformatf("sym%0d_sof", k), int'(got_q[k].sof), int'(exp_q[k].sof));
      chk($sformatf("sym%0d_eof", k), int'(got_q[k].eof), int'(exp_q[k].eof));
    end
    @(negedge clk); #1;
    if (underrun) und++;
    chk("busy_after_eof", int'(busy), 0);
    chk("underrun_seen", int'(und > 0), int'(gap_at > 0));
  endtask

  vec_t vecs[7];
  bit [PL-1:0] pay;

  initial begin
    vecs[0] = '{1'b0, 2, 0,  0, 1'b0, 60};
    vecs[1] = '{1'b1, 1, 0,  0, 1'b1, 46};
    vecs[2] = '{1'b0, 0, 40, 0, 1'b0, 60};
    vecs[3] = '{1'b1, 0, 36, 0, 1'b0, 46};
    vecs[4] = '{1'b0, 0, 0,  3, 1'b0, 60};
    vecs[5] = '{1'b1, 0, 0,  4, 1'b0, 46};
    vecs[6] = '{1'b1, 0, 40, 2, 1'b0, 46};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_i", int'(out_i), 0);
    chk("rst_q", int'(out_q), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_underrun", int'(underrun), 0);

    for (int v = 0; v < 7; v++) begin
      pay = PL'($urandom);
      if (vecs[v].pat == 1) pay = '0;
      if (vecs[v].pat == 2) pay[0] = 1'b1;
      run_frame(vecs[v].m, pay, vecs[v].stall_at, vecs[v].gap_at, vecs[v].tog, 0, vecs[v].exp_n);
      if (v == 0 && got_q.size() >= 34) begin
        chk("pre0", got_q[0].i, A);
        chk("pre1", got_q[1].i, A);
        chk("pre2", got_q[2].i, A);
        chk("pre3", got_q[3].i, -A);
        chk("pre3_q", got_q[3].q, 0);
        chk("sof1_only", int'(got_q[1].sof), 0);
`ifndef SCRAMBLER_EN
        chk("bpsk_bit1_a", got_q[32].i, -A);
        chk("bpsk_bit1_b", got_q[33].i, -A);
`endif
      end
`ifndef SCRAMBLER_EN
      if (v == 1)
        for (int k = PLEN; k < got_q.size(); k++) begin
          chk($sformatf("qpsk0_i%0d", k), got_q[k].i, A);
          chk($sformatf("qpsk0_q%0d", k), got_q[k].q, A);
        end
`endif
      mode = 1'b0;
    end

    // Abort mid-frame with reset, then restart cleanly.
    pay = PL'($urandom);
    run_frame(1'b0, pay, 0, 0, 1'b0, 40, 60);
    chk("abort_reached", got_q.size(), 40);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_i", int'(out_i), 0);
    chk("abort_q", int'(out_q), 0);
    chk("abort_sof", int'(out_sof), 0);
    chk("abort_eof", int'(out_eof), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_underrun", int'(underrun), 0);
    reset = 1'b0;
    pay = PL'($urandom);
    run_frame(1'b1, pay, 0, 0, 1'b0, 0, 46);
    if (got_q.size() > 0) chk("restart_sof", int'(got_q[0].sof), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
